round_key_sequencer: RTL and testbench
======================================

ROUND_KEY_SEQUENCER -- requirements
Module: round_key_sequencer

Interface
REQ-001 Parameter Nb, default 4: state columns (32-bit words per round key).
REQ-002 Parameter Nk, default 4: cipher key words (4/6/8).
REQ-003 Parameter Nr, default 10: rounds (10/12/14); the round-key count is Nr+1.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request to capture key_words and begin a sequence.
REQ-007 decrypt  input  1  sampled with start: 0 issues round 0..Nr; 1 issues round Nr..0.
REQ-008 key_words  input  [0:32*Nb*(Nr+1)-1]  expanded schedule from KeyExpansion; round r occupies bits [128r : 128r+127], big-endian (bit 0 = MSB of w[0]).
REQ-009 ready  input  1  consumer accepts round_key this cycle.
REQ-010 round_key  output  [0:32*Nb-1]  current round key.
REQ-011 round_idx  output  4  index (0..Nr) of round_key.
REQ-012 valid  output  1  round_key/round_idx/last are valid.
REQ-013 last  output  1  current key is the final one of the sequence.
REQ-014 busy  output  1  sequence in progress.
REQ-015 done  output  1  one-cycle pulse after the final transfer.

Function
REQ-016 States: IDLE, ISSUE, DONE; an unlisted state encoding returns to IDLE.
REQ-017 IDLE: when start=1, capture key_words into an internal register, latch decrypt, set round_idx to 0 (encrypt) or Nr (decrypt), and go to ISSUE; valid=1 from the next cycle.
REQ-018 Latency: the first key is valid exactly 1 cycle after start is sampled.
REQ-019 Transfer occurs on a cycle with valid=1 and ready=1; otherwise round_key, round_idx and last hold stable.
REQ-020 On a non-final transfer, round_idx increments (encrypt) or decrements (decrypt) by 1, and the next key is valid the following cycle; back-to-back transfers at 1 key/cycle are supported.
REQ-021 last=1 iff valid=1 and round_idx = Nr (encrypt) or 0 (decrypt).
REQ-022 A transfer with last=1 moves to DONE; DONE asserts done=1, valid=0 for one cycle, then goes to IDLE.
REQ-023 round_key is a mux of the captured register only; changes on key_words after capture have no effect on the sequence.
REQ-024 start is ignored in ISSUE and DONE; a start in the DONE cycle is dropped, and a start on the first IDLE cycle is accepted.
REQ-025 busy=1 in ISSUE and DONE, 0 in IDLE.
REQ-026 round_idx never leaves 0..Nr; no wrap-around.
REQ-027 valid, last and done are registered outputs; round_key is a combinational decode of the registered round_idx.

Reset
REQ-028 reset=1 immediately forces IDLE, with valid=0, last=0, busy=0, done=0, round_idx=0, round_key=0 and the key register cleared, independent of clk.
REQ-029 reset asserted mid-sequence abandons it; no done pulse follows; the first start after release begins a fresh sequence.

Verification
REQ-030 Nr=10, key_words from cipher key 2b7e1516_28aed2a6_abf71588_09cf4f3c, decrypt=0, ready=1 -> 11 consecutive valid cycles; idx0 key 2b7e151628aed2a6abf7158809cf4f3c; idx10 key d014f9a8c9ee2589e13f0cc8b6630ca6 with last=1; done pulse on the next cycle.
REQ-031 Same key, decrypt=1 -> first key d014f9a8c9ee2589e13f0cc8b6630ca6 with idx 10, last at idx 0 with key 2b7e1516..., 11 transfers total.
REQ-032 Nk=6, Nr=12, cipher key 8e73b0f7_..._522c6b7b, ready toggling 1,0,1,0 -> 13 transfers over 25 cycles; key held while ready=0; idx12 key e98ba06f448c773c8ecc720401002202.
REQ-033 Nk=8, Nr=14, cipher key 603deb10_..._0914dff4 -> idx14 key fe4890d1e6188d0b046df344706c631e; key_words changed to all-zero after start leaves the outputs unchanged.
REQ-034 start re-pulsed at idx 3 -> ignored; reset pulsed at idx 5 -> valid=0 asynchronously, no done; a new start then yields idx 0 after 1 cycle.

Source files
------------

// File: rtl/round_key_sequencer.sv
// Round-key sequencer: captures an expanded AES key schedule and streams one
// round key per valid/ready handshake, forward for encryption or reversed for decryption.
module round_key_sequencer #(
    parameter int Nb = 4,
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    decrypt,
    input  logic [0:32*Nb*(Nr+1)-1] key_words,
    input  logic                    ready,
    output logic [0:32*Nb-1]        round_key,
    output logic [3:0]              round_idx,
    output logic                    valid,
    output logic                    last,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned RK_W     = 32 * Nb;
    localparam int unsigned NUM_KEYS = Nr + 1;
    localparam int unsigned SCHED_W  = RK_W * NUM_KEYS;
    localparam logic [3:0]  IDX_LAST = 4'(Nr);

    generate
        if (!(Nk == 4 || Nk == 6 || Nk == 8) || Nr < 1 || Nr > 15) begin : g_bad_cfg
            $error("round_key_sequencer: unsupported Nk/Nr combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           idx_q, idx_d;
    logic                 dec_q, dec_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 done_q, done_d;
    logic [0:SCHED_W-1]   key_q, key_d;

    logic [3:0]           idx_step;
    logic                 step_is_last;

    // Neighbouring index in the current direction and whether it ends the sequence.
    always_comb begin
        idx_step     = dec_q ? (idx_q - 4'd1) : (idx_q + 4'd1);
        step_is_last = dec_q ? (idx_step == 4'd0) : (idx_step == IDX_LAST);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dec_d   = dec_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        key_d   = key_q;
        unique case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                if (start) begin
                    key_d   = key_words;
                    dec_d   = decrypt;
                    idx_d   = decrypt ? IDX_LAST : 4'd0;
                    valid_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (valid_q && ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d  = idx_step;
                        last_d = step_is_last;
                    end
                end
            end
            S_DONE: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            dec_q   <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dec_q   <= dec_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            key_q   <= key_d;
        end
    end

    // Key selection reads only the captured schedule, never key_words.
    always_comb begin
        round_key = '0;
        for (int unsigned r = 0; r < NUM_KEYS; r++) begin
            if (idx_q == 4'(r)) begin
                round_key = key_q[r*RK_W +: RK_W];
            end
        end
    end

    assign round_idx = idx_q;
    assign valid     = valid_q;
    assign last      = last_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_round_key_sequencer.sv
// Scoreboard bench for round_key_sequencer: AES-128/192/256 schedules streamed
// forward and reversed, with ready stalls, ignored starts and mid-sequence reset.
module tb_round_key_sequencer;

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [127:0] K128_LO = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K128_HI = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K192_LO = 128'h8e73b0f7da0e6452c810f32b809079e5;
    localparam logic [127:0] K192_HI = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] K256_LO = 128'h603deb1015ca71be2b73aef0857d7781;
    localparam logic [127:0] K256_HI = 128'hfe4890d1e6188d0b046df344706c631e;

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] key;
        logic         last;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           start   [3];
    logic           decrypt [3];
    logic           ready   [3];
    logic [0:1919]  kw      [3];
    logic [127:0]   rk      [3];
    logic [3:0]     ridx    [3];
    logic           valid   [3];
    logic           last    [3];
    logic           busy    [3];
    logic           done    [3];

    exp_t           sbq [3][$];
    bit             done_exp [3];
    int             n_tests = 0;
    int             n_fail  = 0;
    logic [0:1919]  sched   [3];

    always #5 clk = ~clk;

    round_key_sequencer #(.Nb(4), .Nk(4), .Nr(10)) u_aes128 (
        .clk(clk), .reset(reset), .start(start[0]), .decrypt(decrypt[0]),
        .key_words(kw[0][0:1407]), .ready(ready[0]), .round_key(rk[0]),
        .round_idx(ridx[0]), .valid(valid[0]), .last(last[0]), .busy(busy[0]), .done(done[0])
    );

    round_key_sequencer #(.Nb(4), .Nk(6), .Nr(12)) u_aes192 (
        .clk(clk), .reset(reset), .start(start[1]), .decrypt(decrypt[1]),
        .key_words(kw[1][0:1663]), .ready(ready[1]), .round_key(rk[1]),
        .round_idx(ridx[1]), .valid(valid[1]), .last(last[1]), .busy(busy[1]), .done(done[1])
    );

    round_key_sequencer #(.Nb(4), .Nk(8), .Nr(14)) u_aes256 (
        .clk(clk), .reset(reset), .start(start[2]), .decrypt(decrypt[2]),
        .key_words(kw[2][0:1919]), .ready(ready[2]), .round_key(rk[2]),
        .round_idx(ridx[2]), .valid(valid[2]), .last(last[2]), .busy(busy[2]), .done(done[2])
    );

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = SBOX[8*int'(w[8*b +: 8]) +: 8];
        return r;
    endfunction

    // FIPS-197 KeyExpansion; cipher key is left-aligned in ck.
    function automatic logic [0:1919] expand(input logic [255:0] ck, input int nk, input int nr);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [0:1919] res;
        res = '0;
        rc  = 8'h01;
        for (int i = 0; i < 4*(nr+1); i++) begin
            if (i < nk) begin
                w[i] = ck[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subw(t);
                end
                w[i] = w[i-nk] ^ t;
            end
            res[32*i +: 32] = w[i];
        end
        return res;
    endfunction

    // Monitor: every valid cycle is compared with the queue head; a handshake pops it.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (!reset) begin
                if (done_exp[i]) begin
                    check($sformatf("dut%0d done pulse", i), 128'(done[i]), 128'd1);
                    check($sformatf("dut%0d valid low in done", i), 128'(valid[i]), 128'd0);
                    done_exp[i] = 1'b0;
                end else if (done[i]) begin
                    check($sformatf("dut%0d unexpected done", i), 128'(done[i]), 128'd0);
                end
                if (valid[i]) begin
                    if (sbq[i].size() == 0) begin
                        check($sformatf("dut%0d unexpected valid", i), 128'(valid[i]), 128'd0);
                    end else begin
                        e = sbq[i][0];
                        check($sformatf("dut%0d round_idx", i), 128'(ridx[i]), 128'(e.idx));
                        check($sformatf("dut%0d round_key idx%0d", i, e.idx), rk[i], e.key);
                        check($sformatf("dut%0d last idx%0d", i, e.idx), 128'(last[i]), 128'(e.last));
                        if (ready[i]) begin
                            void'(sbq[i].pop_front());
                            if (e.last) done_exp[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic issue(input int i, input bit dec, input int nr,
                         input logic [127:0] key_lo, input logic [127:0] key_hi);
        exp_t e;
        int   r;
        for (int k = 0; k <= nr; k++) begin
            r      = dec ? nr - k : k;
            e.idx  = 4'(r);
            e.key  = (r == nr) ? key_hi : (r == 0) ? key_lo : sched[i][128*r +: 128];
            e.last = (k == nr);
            sbq[i].push_back(e);
        end
        decrypt[i] = dec;
        start[i]   = 1'b1;
        @(posedge clk);
        #1;
        start[i]   = 1'b0;
        decrypt[i] = ~dec;
    endtask

    task automatic wait_done(input int i, input int budget, input bit toggle,
                             output int vc, output int cyc);
        bit got;
        got = 1'b0;
        vc  = 0;
        cyc = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            cyc = c;
            if (c == 1) check($sformatf("dut%0d first-key latency", i), 128'(valid[i]), 128'd1);
            if (done[i]) begin
                got = 1'b1;
                break;
            end
            if (valid[i]) vc++;
            if (toggle) begin
                @(posedge clk);
                #1;
                ready[i] = ~ready[i];
            end
        end
        if (!got) timeout_fail($sformatf("dut%0d done", i));
    endtask

    task automatic wait_idx(input int i, input logic [3:0] want);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (valid[i] && ridx[i] == want) got = 1'b1;
        end
        if (!got) timeout_fail($sformatf("dut%0d reach idx%0d", i, want));
    endtask

    initial begin
        int vc, cyc;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0; decrypt[i] = 1'b0; ready[i] = 1'b0; kw[i] = '0; done_exp[i] = 1'b0;
        end
        sched[0] = expand({K128_LO, 128'h0}, 4, 10);
        sched[1] = expand({192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 6, 12);
        sched[2] = expand(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 8, 14);
        #12;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("dut%0d reset valid", i), 128'(valid[i]), 128'd0);
            check($sformatf("dut%0d reset last", i), 128'(last[i]), 128'd0);
            check($sformatf("dut%0d reset busy", i), 128'(busy[i]), 128'd0);
            check($sformatf("dut%0d reset done", i), 128'(done[i]), 128'd0);
            check($sformatf("dut%0d reset idx", i), 128'(ridx[i]), 128'd0);
            check($sformatf("dut%0d reset key", i), rk[i], 128'd0);
        end
        for (int i = 0; i < 3; i++) kw[i] = sched[i];
        @(posedge clk);
        #1;
        reset = 1'b0;

        // AES-128 encrypt at full rate, then a start during DONE must be dropped.
        ready[0] = 1'b1;
        issue(0, 1'b0, 10, K128_LO, K128_HI);
        wait_done(0, 40, 1'b0, vc, cyc);
        check("aes128 enc valid cycles", 128'(vc), 128'd11);
        check("aes128 enc done cycle", 128'(cyc), 128'd12);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        @(negedge clk);
        check("start in done dropped valid", 128'(valid[0]), 128'd0);
        check("start in done dropped busy", 128'(busy[0]), 128'd0);

        // AES-128 decrypt, started on the first IDLE cycle.
        issue(0, 1'b1, 10, K128_LO, K128_HI);
        wait_done(0, 40, 1'b0, vc, cyc);
        check("aes128 dec valid cycles", 128'(vc), 128'd11);

        // AES-192 with ready alternating 1,0,1,0...
        ready[1] = 1'b1;
        issue(1, 1'b0, 12, K192_LO, K192_HI);
        wait_done(1, 80, 1'b1, vc, cyc);
        check("aes192 stalled valid cycles", 128'(vc), 128'd25);
        check("aes192 all keys transferred", 128'(sbq[1].size()), 128'd0);

        // AES-256 with key_words wiped right after capture.
        ready[2] = 1'b1;
        issue(2, 1'b0, 14, K256_LO, K256_HI);
        kw[2] = '0;
        wait_done(2, 40, 1'b0, vc, cyc);
        check("aes256 valid cycles", 128'(vc), 128'd15);

        // Restart ignored mid-sequence, then reset abandons it.
        issue(0, 1'b0, 10, K128_LO, K128_HI);
        wait_idx(0, 4'd3);
        @(posedge clk);
        #1;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        wait_idx(0, 4'd5);
        #2;
        reset = 1'b1;
        #1;
        check("async reset valid", 128'(valid[0]), 128'd0);
        check("async reset busy", 128'(busy[0]), 128'd0);
        check("async reset last", 128'(last[0]), 128'd0);
        check("async reset idx", 128'(ridx[0]), 128'd0);
        check("async reset key", rk[0], 128'd0);
        sbq[0].delete();
        done_exp[0] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("no done after reset", 128'(done[0]), 128'd0);
        end
        issue(0, 1'b0, 10, K128_LO, K128_HI);
        wait_done(0, 40, 1'b0, vc, cyc);
        check("fresh sequence valid cycles", 128'(vc), 128'd11);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
